// File: rtl/std_div_stream_pkg.sv
// std_div_stream_pkg: shared FSM state type and divide-by-zero quotient constant
package std_div_stream_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;
  localparam int max_width = 64;
  function automatic logic [max_width-1:0] dz_quotient(input int w);
    return (w >= max_width) ? '1 : (max_width'(1) << w) - max_width'(1);
  endfunction
endpackage

// File: rtl/std_div_pipe.sv
// std_div_pipe: restoring shift-subtract divider, held idle while go is low, done stays high until go drops
module std_div_pipe #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             go,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             done,
  output logic [width-1:0] quotient,
  output logic [width-1:0] remainder
);
  localparam int cw = $clog2(width + 1);
  logic          run;
  logic [cw-1:0] cnt;
  logic [width-1:0] d;
  logic [width:0] shifted, diff;
  assign shifted = {remainder, quotient[width-1]};
  assign diff = shifted - {1'b0, d};
  // a zero dividend skips the iterations entirely
  always_ff @(posedge clk)
    if (!go) begin
      run <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
    end else if (!run && !done) begin
      run <= 1'b1;
      cnt <= (a == '0) ? '0 : cw'(width);
      remainder <= '0;
      quotient <= a;
      d <= b;
    end else if (run && cnt != '0) begin
      remainder <= diff[width] ? shifted[width-1:0] : diff[width-1:0];
      quotient <= {quotient[width-2:0], ~diff[width]};
      cnt <= cnt - cw'(1);
    end else if (run) begin
      run <= 1'b0;
      done <= 1'b1;
    end
endmodule

// File: rtl/std_div_stream.sv
// std_div_stream: queued unsigned divider with valid/ready streaming and divide-by-zero bypass
module std_div_stream
  import std_div_stream_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_left,
  input  logic [width-1:0] in_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_quotient,
  output logic [width-1:0] out_remainder,
  output logic             out_div_by_zero
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = 1;
  localparam logic [width-1:0] dz_q = width'(dz_quotient(width));
  logic [width-1:0] mem_left [depth];
  logic [width-1:0] mem_right [depth];
  logic [aw:0] wr_ptr, rd_ptr;
  logic empty, full, push, pop, div_done, go;
  logic [width-1:0] lat_left, lat_right, div_q, div_r, head_left, head_right;
  state_t state;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign in_ready = !full;
  assign push = in_valid && !full;
  // output register counts as free when it is handing off on this same edge
  assign pop = (state == IDLE) && !empty && (!out_valid || out_ready);
  assign head_left = mem_left[rd_ptr[aw-1:0]];
  assign head_right = mem_right[rd_ptr[aw-1:0]];
  always_ff @(posedge clk)
    if (push) begin
      mem_left[wr_ptr[aw-1:0]] <= in_left;
      mem_right[wr_ptr[aw-1:0]] <= in_right;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      state <= IDLE;
      go <= 1'b0;
      lat_left <= '0;
      lat_right <= '0;
      out_valid <= 1'b0;
      out_quotient <= '0;
      out_remainder <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (pop) begin
        rd_ptr <= rd_ptr + ptr_one;
        if (head_right == '0) begin
          out_valid <= 1'b1;
          out_quotient <= dz_q;
          out_remainder <= head_left;
          out_div_by_zero <= 1'b1;
        end else begin
          lat_left <= head_left;
          lat_right <= head_right;
          go <= 1'b1;
          state <= ISSUE;
        end
      end else if (state == ISSUE && div_done) begin
        out_valid <= 1'b1;
        out_quotient <= div_q;
        out_remainder <= div_r;
        out_div_by_zero <= 1'b0;
        go <= 1'b0;
        state <= RELEASE;
      end else if (state == RELEASE) begin
        state <= IDLE;
      end
    end
  std_div_pipe #(.width(width)) u_pipe (
    .clk(clk),
    .go(go),
    .a(lat_left),
    .b(lat_right),
    .done(div_done),
    .quotient(div_q),
    .remainder(div_r)
  );
endmodule

// File: tb/tb_std_div_stream.sv
// tb_std_div_stream: randomized scoreboard bench for std_div_stream (width 32 and width 8 instances)
module tb_std_div_stream;
  typedef struct packed {logic dz; logic [31:0] q; logic [31:0] r;} res_t;
  logic clk = 0, reset_n = 1;
  logic in_valid = 0, out_ready = 0, in_ready, out_valid, out_div_by_zero;
  logic [31:0] in_left = 0, in_right = 0, out_quotient, out_remainder;
  logic in_valid8 = 0, out_ready8 = 1, in_ready8, out_valid8, out_dz8;
  logic [7:0] in_left8 = 0, in_right8 = 0, out_q8, out_r8;
  int n_cmp = 0, n_bad = 0, go_cycles = 0;
  res_t got_q[$], exp_q[$];

  std_div_stream dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder), .out_div_by_zero(out_div_by_zero));

  std_div_stream #(.width(8), .depth(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_left(in_left8), .in_right(in_right8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_quotient(out_q8), .out_remainder(out_r8), .out_div_by_zero(out_dz8));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_div_by_zero, out_quotient, out_remainder});
    if (dut.go) go_cycles++;
  end

  function automatic res_t model(input logic [31:0] l, input logic [31:0] r);
    if (r == 0) return {1'b1, 32'hFFFF_FFFF, l};
    return {1'b0, l / r, l % r};
  endfunction

  task automatic send(input logic [31:0] l, input logic [31:0] r);
    int t = 0;
    in_valid = 1; in_left = l; in_right = r;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL send_accept in_ready=%b required 1 (operands %0d/%0d)", in_ready, l, r);
    end else begin
      @(posedge clk); #1;
      exp_q.push_back(model(l, r));
    end
    in_valid = 0;
  endtask

  task automatic drain(input int n, input int budget);
    int t = 0;
    while (got_q.size() < n && t < budget) begin @(posedge clk); #1; t++; end
  endtask

  task automatic test_reset;
    #1 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_quotient, out_remainder, out_div_by_zero} !== 66'd0 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL reset_outputs v=%b q=%h r=%h dz=%b rdy=%b required all 0, rdy 1",
               out_valid, out_quotient, out_remainder, out_div_by_zero, in_ready);
    end
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1 || out_valid !== 0) begin
      n_bad++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic;
    got_q.delete(); exp_q.delete();
    out_ready = 1;
    send(100, 7);
    send(32'hFFFF_FFFF, 1);
    send(1, 32'hFFFF_FFFF);
    send(32'hDEAD_BEEF, 32'h0001_0001);
    drain(exp_q.size(), 400);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      res_t g = i < got_q.size() ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic[%0d] got=%h required %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_dividend;
    int t = 0;
    got_q.delete(); exp_q.delete();
    out_ready = 1;
    send(0, 5);
    while (!out_valid && t < 20) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (!out_valid || t > 4 || out_quotient !== 0 || out_remainder !== 0 || out_div_by_zero !== 0) begin
      n_bad++;
      $display("FAIL zero_dividend cycles=%0d v=%b q=%h r=%h dz=%b required <=4 cycles, q=0 r=0 dz=0",
               t, out_valid, out_quotient, out_remainder, out_div_by_zero);
    end
    drain(1, 10);
  endtask

  task automatic test_div_by_zero;
    int g0;
    time t0;
    got_q.delete(); exp_q.delete();
    out_ready = 1;
    g0 = go_cycles;
    t0 = $time;
    send(9, 0);
    for (int i = 0; i < 7; i++) send($urandom, 0);
    n_cmp++;
    if ($time - t0 != 80) begin
      n_bad++;
      $display("FAIL dz_rate elapsed=%0t required 80", $time - t0);
    end
    drain(8, 50);
    n_cmp++;
    if (go_cycles != g0) begin
      n_bad++;
      $display("FAIL dz_go go_cycles=%0d required %0d", go_cycles, g0);
    end
    n_cmp++;
    if (got_q.size() != 8) begin
      n_bad++;
      $display("FAIL dz_count got=%0d required 8", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      res_t g = i < got_q.size() ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL dz[%0d] got=%h required %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    res_t first;
    got_q.delete(); exp_q.delete();
    out_ready = 0;
    send(20, 3);
    send(17, 17);
    send(5, 0);
    n_cmp++;
    if (in_ready !== 0) begin
      n_bad++;
      $display("FAIL b2b_full in_ready=%b required 0 after 3 accepts", in_ready);
    end
    repeat (60) @(posedge clk);
    #1;
    first = exp_q[0];
    n_cmp++;
    if (out_valid !== 1 || in_ready !== 0 || out_quotient !== first.q || out_remainder !== first.r) begin
      n_bad++;
      $display("FAIL b2b_hold v=%b rdy=%b q=%h r=%h required v=1 rdy=0 q=%h r=%h",
               out_valid, in_ready, out_quotient, out_remainder, first.q, first.r);
    end
    out_ready = 1;
    send(1, 2);
    drain(4, 400);
    n_cmp++;
    if (got_q.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d required 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      res_t g = i < got_q.size() ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL b2b[%0d] got=%h required %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    got_q.delete(); exp_q.delete();
    out_ready = 1;
    send(1000, 3);
    repeat (10) @(posedge clk);
    #1 reset_n = 0;
    #1;
    n_cmp++;
    if ({out_valid, out_quotient, out_remainder, out_div_by_zero} !== 66'd0 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL midreset_outputs v=%b q=%h r=%h dz=%b rdy=%b required all 0, rdy 1",
               out_valid, out_quotient, out_remainder, out_div_by_zero, in_ready);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    send(8, 2);
    drain(1, 100);
    repeat (50) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 1) begin
      n_bad++;
      $display("FAIL midreset_count got=%0d required 1", got_q.size());
    end
    n_cmp++;
    if (got_q.size() < 1 || got_q[0] !== {1'b0, 32'd4, 32'd0}) begin
      n_bad++;
      $display("FAIL midreset_8_2 got=%h required %h", got_q.size() ? got_q[0] : 'x, {1'b0, 32'd4, 32'd0});
    end
  endtask

  task automatic test_random;
    bit tx_done = 0;
    got_q.delete(); exp_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] l, r;
          int mode;
          mode = $urandom_range(0, 7);
          l = $urandom;
          r = mode == 0 ? 0 : mode < 3 ? 32'($urandom_range(1, 300)) : $urandom;
          if (mode == 3) l = 0;
          if (mode == 4) l = 32'($urandom_range(0, 50));
          send(l, r);
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        tx_done = 1;
      end
      begin
        while (!tx_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain(exp_q.size(), 5000);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random_count got=%0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      res_t g = i < got_q.size() ? got_q[i] : 'x;
      n_cmp++;
      if (g !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random[%0d] got=%h required %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_width8;
    logic [7:0] ls [5] = '{8'd255, 8'd1, 8'd200, 8'd0, 8'd77};
    logic [7:0] rs [5] = '{8'd1, 8'd255, 8'd0, 8'd7, 8'd7};
    for (int i = 0; i < 5; i++) begin
      int t = 0;
      logic [16:0] want;
      want = rs[i] == 0 ? {1'b1, 8'hFF, ls[i]} : {1'b0, 8'(ls[i] / rs[i]), 8'(ls[i] % rs[i])};
      in_valid8 = 1; in_left8 = ls[i]; in_right8 = rs[i];
      while (!in_ready8 && t < 50) begin @(posedge clk); #1; t++; end
      @(posedge clk); #1;
      in_valid8 = 0;
      t = 0;
      while (!out_valid8 && t < 30) begin @(posedge clk); #1; t++; end
      n_cmp++;
      if (out_valid8 !== 1 || {out_dz8, out_q8, out_r8} !== want) begin
        n_bad++;
        $display("FAIL w8[%0d] %0d/%0d v=%b got=%h required %h",
                 i, ls[i], rs[i], out_valid8, {out_dz8, out_q8, out_r8}, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_dividend();
    test_div_by_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/std_div_stream.md
STD_DIV_STREAM -- requirements
Module: std_div_stream

Interface
REQ-001 Parameter width, default 32: operand and result bit width.
REQ-002 Parameter depth, default 2: input queue entries, power of two, min 2.
REQ-003 Clock and reset:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
REQ-004 Input side:
- in_valid  in  1  operand pair present.
- in_ready  out  1  queue can accept.
- in_left  in  width  unsigned dividend.
- in_right  in  width  unsigned divisor.
REQ-005 Output side:
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts.
- out_quotient  out  width  quotient.
- out_remainder  out  width  remainder.
- out_div_by_zero  out  1  in_right was 0.

Function
REQ-006 The input transfer SHALL occur on an edge with in_valid&&in_ready; output transfer on out_valid&&out_ready; valid SHALL NOT depend combinationally on ready.
REQ-007 The input queue SHALL be a depth-entry FIFO with wrap-around pointers; in_ready = !full, held independently of out_ready; simultaneous push and pop when full SHALL NOT be accepted (in_ready low).
REQ-008 The FSM SHALL have states IDLE, ISSUE, RELEASE, with transitions below.
REQ-009 IDLE: if queue non-empty and output register empty, pop head; right==0 -> load output register directly (quotient all-ones, remainder = left, div_by_zero=1), stay IDLE; else latch operands, go to ISSUE.
REQ-010 ISSUE: hold divider go high with latched operands constant; on first cycle div done is high, capture quotient/remainder into output register (div_by_zero=0), go to RELEASE.
REQ-011 RELEASE: go low for exactly one cycle to clear the divider; then IDLE.
REQ-012 The block SHALL rely only on done, never a cycle count (divider latency is width+2 cycles for nonzero dividend, 2 for zero dividend).
REQ-013 The output register SHALL hold values stable while out_valid && !out_ready; out_valid clears on transfer.
REQ-014 The output register SHALL count as empty in IDLE if it transfers on that same edge (pop and load allowed together).
REQ-015 Results SHALL emerge in input order; no operand pair is dropped or duplicated.
REQ-016 Minimum issue spacing SHALL be: divider op -> next op after RELEASE; divide-by-zero ops at one per cycle.

Reset
REQ-017 On reset_n low: FIFO empty, pointers 0, state IDLE, go 0, out_valid 0, out_quotient 0, out_remainder 0, out_div_by_zero 0, in_ready 1 from the first edge after release.
REQ-018 Reset mid-operation SHALL abandon the in-flight op; go=0 returns the divider to idle, so no stale done is captured after reset.

Structure
REQ-019 Package std_div_stream_pkg SHALL hold the state enum typedef and the div-by-zero quotient constant generator (all-ones of width).
REQ-020 One sub-module instance: std_div_pipe (width passed through), driven by clk, go, latched operands.

Verification
REQ-021 100/7 (width 32) -> quotient 14, remainder 2, div_by_zero 0, out_valid after done.
REQ-022 0/5 -> quotient 0, remainder 0; out_valid within 4 cycles of acceptance.
REQ-023 9/0 -> quotient 0xFFFFFFFF, remainder 9, div_by_zero 1, divider go never asserted.
REQ-024 Four pairs back-to-back, out_ready held 0 -> in_ready drops after depth+1 accepts; on release results 20/3, 17/17, 5/0, 1/2 emerge in order.
REQ-025 reset_n low 10 cycles into 1000/3 -> all outputs 0, in_ready 1; next 8/2 -> quotient 4, remainder 0.
REQ-026 width 8: 255/1 -> 255 rem 0; 1/255 -> 0 rem 1.
